// File: rtl/cp0_commit_unit.sv
// cp0_commit_unit
//
// Registered CP0 state and commit-side control for the mycpu pipeline.
// One instruction may commit per cycle. An exception or ERET commit produces a
// one-cycle fetch redirect pulse on the following cycle. The core CP0
// registers are held in flops inside this block: BadVAddr, Count, Compare,
// Status, Cause, EPC and ErrorEPC.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ext_int             external interrupt levels (N_EXT_INT lines)
//   c_valid ... c_wdata commit-side information for the retiring instruction
//   rd_addr / rd_data   MFC0 read port (combinational)
//   int_pending         an enabled, unmasked interrupt is pending
//   redirect_valid/_pc  registered fetch redirect pulse and target
//   status_out/epc_out  current Status and EPC
//
// Configuration macro:
//   CP0_MFC0_BYPASS_EN  when defined, an MFC0 that reads the register being
//                       written by a same-cycle MTC0 sees the post-write value.

module cp0_commit_unit #(
  parameter int          N_EXT_INT     = 6,
  parameter int          COUNT_DIV     = 2,
  parameter logic [31:0] VEC_BEV_BASE  = 32'hbfc00200,
  parameter logic [31:0] VEC_NORM_BASE = 32'h80000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_EXT_INT-1:0] ext_int,
  input  logic                 c_valid,
  input  logic [31:0]          c_pc,
  input  logic                 c_exc,
  input  logic [4:0]           c_code,
  input  logic                 c_delayed,
  input  logic [31:0]          c_badvaddr,
  input  logic                 c_eret,
  input  logic                 c_mtc0,
  input  logic [4:0]           c_cp0_addr,
  input  logic [31:0]          c_wdata,
  input  logic [4:0]           rd_addr,
  output logic [31:0]          rd_data,
  output logic                 int_pending,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic [31:0]          status_out,
  output logic [31:0]          epc_out
);

  localparam int            PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_ERROREPC = 5'd30;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  // Status bit positions
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_ERL = 2;
  localparam int ST_BEV = 22;

  // Architectural state
  logic [31:0]          status_q,   status_d;
  logic [31:0]          epc_q,      epc_d;
  logic [31:0]          errorepc_q, errorepc_d;
  logic [31:0]          badvaddr_q, badvaddr_d;
  logic [31:0]          count_q,    count_d;
  logic [31:0]          compare_q,  compare_d;
  logic [PW-1:0]        presc_q,    presc_d;
  logic                 cause_bd_q, cause_bd_d;
  logic                 cause_ti_q, cause_ti_d;
  logic                 cause_iv_q, cause_iv_d;
  logic [1:0]           cause_swip_q, cause_swip_d;
  logic [4:0]           cause_exc_q,  cause_exc_d;
  logic [N_EXT_INT-1:0] ext_int_q,  ext_int_d;
  logic                 redirect_valid_q, redirect_valid_d;
  logic [31:0]          redirect_pc_q,    redirect_pc_d;

  // Decoded commit actions, already resolved for priority exc > eret > mtc0
  logic commit_exc, commit_eret, commit_mtc0;
  logic wr_badvaddr, wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_errorepc;
  logic count_inc;

  logic [7:0]  cause_ip;
  logic [31:0] cause_val;
  logic [31:0] rd_current;

  // Interrupt-pending vector: software bits, registered external lines, and
  // the timer folded into the top bit alongside the last external line.
  function automatic logic [7:0] build_ip(input logic [1:0]           swip,
                                          input logic [N_EXT_INT-1:0] ext,
                                          input logic                 ti);
    logic [7:0] ip;
    ip = {6'b0, swip};
    for (int i = 0; i < N_EXT_INT; i++) begin
      ip[2+i] = ext[i];
    end
    ip[7] = ip[7] | ti;
    return ip;
  endfunction

  function automatic logic [31:0] pack_cause(input logic       bd,
                                             input logic       ti,
                                             input logic       iv,
                                             input logic [7:0] ip,
                                             input logic [4:0] exc);
    return {bd, ti, 6'b0, iv, 7'b0, ip, 1'b0, exc, 2'b0};
  endfunction

  function automatic logic [31:0] read_sel(input logic [4:0]  addr,
                                           input logic [31:0] badv,
                                           input logic [31:0] cnt,
                                           input logic [31:0] cmp,
                                           input logic [31:0] st,
                                           input logic [31:0] cause,
                                           input logic [31:0] epc,
                                           input logic [31:0] errepc);
    logic [31:0] v;
    case (addr)
      REG_BADVADDR: v = badv;
      REG_COUNT:    v = cnt;
      REG_COMPARE:  v = cmp;
      REG_STATUS:   v = st;
      REG_CAUSE:    v = cause;
      REG_EPC:      v = epc;
      REG_ERROREPC: v = errepc;
      default:      v = 32'h0;
    endcase
    return v;
  endfunction

  // Current Cause value as seen by software and by the interrupt logic.
  always_comb begin
    cause_ip  = build_ip(cause_swip_q, ext_int_q, cause_ti_q);
    cause_val = pack_cause(cause_bd_q, cause_ti_q, cause_iv_q, cause_ip, cause_exc_q);
  end

  // Commit decode. Only one of exc / eret / mtc0 takes effect per cycle.
  always_comb begin
    commit_exc  = c_valid & c_exc;
    commit_eret = c_valid & ~c_exc & c_eret;
    commit_mtc0 = c_valid & ~c_exc & ~c_eret & c_mtc0;

    wr_badvaddr = commit_mtc0 & (c_cp0_addr == REG_BADVADDR);
    wr_count    = commit_mtc0 & (c_cp0_addr == REG_COUNT);
    wr_compare  = commit_mtc0 & (c_cp0_addr == REG_COMPARE);
    wr_status   = commit_mtc0 & (c_cp0_addr == REG_STATUS);
    wr_cause    = commit_mtc0 & (c_cp0_addr == REG_CAUSE);
    wr_epc      = commit_mtc0 & (c_cp0_addr == REG_EPC);
    wr_errorepc = commit_mtc0 & (c_cp0_addr == REG_ERROREPC);
  end

  // Next-state computation for every CP0 register and the redirect.
  always_comb begin
    status_d         = status_q;
    epc_d            = epc_q;
    errorepc_d       = errorepc_q;
    badvaddr_d       = badvaddr_q;
    count_d          = count_q;
    compare_d        = compare_q;
    presc_d          = presc_q;
    cause_bd_d       = cause_bd_q;
    cause_ti_d       = cause_ti_q;
    cause_iv_d       = cause_iv_q;
    cause_swip_d     = cause_swip_q;
    cause_exc_d      = cause_exc_q;
    ext_int_d        = ext_int;
    redirect_valid_d = commit_exc | commit_eret;
    redirect_pc_d    = redirect_pc_q;
    count_inc        = 1'b0;

    // A software Count load restarts the prescaler and suppresses the
    // increment that would otherwise happen this cycle.
    if (wr_count) begin
      count_d = c_wdata;
      presc_d = '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d   = '0;
      count_d   = count_q + 32'd1;
      count_inc = 1'b1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (count_inc && ((count_q + 32'd1) == compare_q)) begin
      cause_ti_d = 1'b1;
    end

    // Writing Compare acknowledges the timer; it wins over a same-cycle match.
    if (wr_compare) begin
      compare_d  = c_wdata;
      cause_ti_d = 1'b0;
    end

    if (commit_exc) begin
      // A nested exception (EXL already set) keeps the original EPC/BD so
      // that the outer handler can still return correctly.
      if (!status_q[ST_EXL]) begin
        epc_d      = c_delayed ? (c_pc - 32'd4) : c_pc;
        cause_bd_d = c_delayed;
      end
      status_d[ST_EXL] = 1'b1;
      cause_exc_d      = c_code;
      if (c_code == 5'd4 || c_code == 5'd5) begin
        badvaddr_d = c_badvaddr;
      end
      redirect_pc_d = (status_q[ST_BEV] ? VEC_BEV_BASE : VEC_NORM_BASE) +
                      (((c_code == 5'd0) && cause_iv_q) ? 32'h200 : 32'h180);
    end else if (commit_eret) begin
      if (status_q[ST_ERL]) begin
        status_d[ST_ERL] = 1'b0;
        redirect_pc_d    = errorepc_q;
      end else begin
        status_d[ST_EXL] = 1'b0;
        redirect_pc_d    = epc_q;
      end
    end

    if (wr_badvaddr) badvaddr_d = c_wdata;
    if (wr_status)   status_d   = c_wdata;
    if (wr_epc)      epc_d      = c_wdata;
    if (wr_errorepc) errorepc_d = c_wdata;
    // Only IV and the two software interrupt bits of Cause are writable.
    if (wr_cause) begin
      cause_iv_d   = c_wdata[23];
      cause_swip_d = c_wdata[9:8];
    end
  end

  // State register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q         <= STATUS_RESET;
      epc_q            <= 32'h0;
      errorepc_q       <= 32'h0;
      badvaddr_q       <= 32'h0;
      count_q          <= 32'h0;
      compare_q        <= 32'h0;
      presc_q          <= '0;
      cause_bd_q       <= 1'b0;
      cause_ti_q       <= 1'b0;
      cause_iv_q       <= 1'b0;
      cause_swip_q     <= 2'b0;
      cause_exc_q      <= 5'b0;
      ext_int_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
    end else begin
      status_q         <= status_d;
      epc_q            <= epc_d;
      errorepc_q       <= errorepc_d;
      badvaddr_q       <= badvaddr_d;
      count_q          <= count_d;
      compare_q        <= compare_d;
      presc_q          <= presc_d;
      cause_bd_q       <= cause_bd_d;
      cause_ti_q       <= cause_ti_d;
      cause_iv_q       <= cause_iv_d;
      cause_swip_q     <= cause_swip_d;
      cause_exc_q      <= cause_exc_d;
      ext_int_q        <= ext_int_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // MFC0 read port.
  always_comb begin
    rd_current = read_sel(rd_addr, badvaddr_q, count_q, compare_q, status_q,
                          cause_val, epc_q, errorepc_q);
  end

`ifdef CP0_MFC0_BYPASS_EN
  logic [31:0] cause_next;
  logic [31:0] rd_next;

  // Post-write view of the register file, used when the MFC0 targets the
  // register an MTC0 is writing in the same cycle.
  always_comb begin
    cause_next = pack_cause(cause_bd_d, cause_ti_d, cause_iv_d,
                            build_ip(cause_swip_d, ext_int_d, cause_ti_d),
                            cause_exc_d);
    rd_next    = read_sel(rd_addr, badvaddr_d, count_d, compare_d, status_d,
                          cause_next, epc_d, errorepc_d);
    if (c_valid && c_mtc0 && (c_cp0_addr == rd_addr)) begin
      rd_data = rd_next;
    end else begin
      rd_data = rd_current;
    end
  end
`else
  assign rd_data = rd_current;
`endif

  // Interrupts are taken only with IE set and outside exception/error level.
  assign int_pending = status_q[ST_IE] & ~status_q[ST_EXL] & ~status_q[ST_ERL] &
                       (|(cause_ip & status_q[15:8]));

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign status_out     = status_q;
  assign epc_out        = epc_q;

endmodule

// File: tb/tb_cp0_commit_unit.sv
// Testbench for cp0_commit_unit: directed scenarios with hand-derived
// constants, followed by randomized commits checked against a behavioural
// model of the CP0 registers.

module tb_cp0_commit_unit;

  localparam int          N   = 6;
  localparam int          DIV = 2;
  localparam logic [31:0] BEV_BASE  = 32'hbfc00200;
  localparam logic [31:0] NORM_BASE = 32'h80000000;

  logic          clk;
  logic          reset;
  logic [N-1:0]  ext_int;
  logic          c_valid;
  logic [31:0]   c_pc;
  logic          c_exc;
  logic [4:0]    c_code;
  logic          c_delayed;
  logic [31:0]   c_badvaddr;
  logic          c_eret;
  logic          c_mtc0;
  logic [4:0]    c_cp0_addr;
  logic [31:0]   c_wdata;
  logic [4:0]    rd_addr;
  logic [31:0]   rd_data;
  logic          int_pending;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [31:0]   status_out;
  logic [31:0]   epc_out;

  int total;
  int bad;

  cp0_commit_unit #(
    .N_EXT_INT    (N),
    .COUNT_DIV    (DIV),
    .VEC_BEV_BASE (BEV_BASE),
    .VEC_NORM_BASE(NORM_BASE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ext_int       (ext_int),
    .c_valid       (c_valid),
    .c_pc          (c_pc),
    .c_exc         (c_exc),
    .c_code        (c_code),
    .c_delayed     (c_delayed),
    .c_badvaddr    (c_badvaddr),
    .c_eret        (c_eret),
    .c_mtc0        (c_mtc0),
    .c_cp0_addr    (c_cp0_addr),
    .c_wdata       (c_wdata),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .int_pending   (int_pending),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .status_out    (status_out),
    .epc_out       (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents. Count is kept as a
  // load value plus elapsed cycles rather than as a prescaled counter.
  logic [31:0] m_status, m_epc, m_errorepc, m_badv, m_compare, m_count_base;
  longint      m_cycles;
  logic        m_bd, m_ti, m_iv;
  logic [1:0]  m_swip;
  logic [4:0]  m_exc;
  logic [5:0]  m_ext;
  logic        m_rv;
  logic [31:0] m_rpc;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mCount();
    return m_count_base + 32'(m_cycles / DIV);
  endfunction

  function automatic logic [7:0] mIp();
    return {m_ext[5] | m_ti, m_ext[4:0], m_swip};
  endfunction

  function automatic logic [31:0] mCause();
    logic [31:0] v;
    v = 32'h0;
    if (m_bd) v = v + 32'h8000_0000;
    if (m_ti) v = v + 32'h4000_0000;
    if (m_iv) v = v + 32'h0080_0000;
    v = v + (32'(mIp()) * 256) + (32'(m_exc) * 4);
    return v;
  endfunction

  function automatic logic [31:0] mRead(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return mCount();
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return mCause();
      5'd14:   return m_epc;
      5'd30:   return m_errorepc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic mIntPending();
    return m_status[0] && !m_status[1] && !m_status[2] && ((mIp() & m_status[15:8]) != 8'h0);
  endfunction

  task automatic modelReset();
    m_status = 32'h0040_0000;
    m_epc = 0; m_errorepc = 0; m_badv = 0; m_compare = 0; m_count_base = 0;
    m_cycles = 0;
    m_bd = 0; m_ti = 0; m_iv = 0; m_swip = 0; m_exc = 0; m_ext = 0;
    m_rv = 0; m_rpc = 0;
  endtask

  // Advance the model across one rising edge with the currently driven inputs.
  task automatic modelStep();
    logic [31:0] old_count;
    logic        do_mtc0;
    if (reset) begin
      modelReset();
      return;
    end
    old_count = mCount();
    do_mtc0   = c_valid && !c_exc && !c_eret && c_mtc0;
    m_rv      = c_valid && (c_exc || c_eret);
    if (c_valid && c_exc) begin
      m_rpc = (m_status[22] ? BEV_BASE : NORM_BASE) + ((c_code == 0 && m_iv) ? 32'h200 : 32'h180);
      if (!m_status[1]) begin
        m_epc = c_delayed ? c_pc - 4 : c_pc;
        m_bd  = c_delayed;
      end
      m_status[1] = 1'b1;
      m_exc = c_code;
      if (c_code == 4 || c_code == 5) m_badv = c_badvaddr;
    end else if (c_valid && c_eret) begin
      if (m_status[2]) begin
        m_rpc = m_errorepc;
        m_status[2] = 1'b0;
      end else begin
        m_rpc = m_epc;
        m_status[1] = 1'b0;
      end
    end
    if (do_mtc0 && c_cp0_addr == 9) begin
      m_count_base = c_wdata;
      m_cycles = 0;
    end else begin
      m_cycles++;
      if (mCount() != old_count && mCount() == m_compare) m_ti = 1'b1;
    end
    if (do_mtc0) begin
      case (c_cp0_addr)
        5'd8:  m_badv = c_wdata;
        5'd11: begin m_compare = c_wdata; m_ti = 1'b0; end
        5'd12: m_status = c_wdata;
        5'd13: begin m_iv = c_wdata[23]; m_swip = c_wdata[9:8]; end
        5'd14: m_epc = c_wdata;
        5'd30: m_errorepc = c_wdata;
        default: ;
      endcase
    end
    m_ext = ext_int;
  endtask

  task automatic applyStimulus(input logic v, input logic exc, input logic eret, input logic mtc0,
                               input logic [4:0] code, input logic [4:0] addr, input logic [4:0] rda,
                               input logic [31:0] pc, input logic [31:0] wdata,
                               input logic [31:0] badv, input logic dly);
    c_valid = v; c_exc = exc; c_eret = eret; c_mtc0 = mtc0;
    c_code = code; c_cp0_addr = addr; rd_addr = rda;
    c_pc = pc; c_wdata = wdata; c_badvaddr = badv; c_delayed = dly;
  endtask

  task automatic idle(input logic [4:0] rda);
    applyStimulus(0, 0, 0, 0, 0, 0, rda, 0, 0, 0, 0);
    #1;
  endtask

  // Compare all outputs against the model, step the model, move to next negedge.
  task automatic runCycle();
    logic [31:0] got_rd, exp_rd;
    #1;
    got_rd = rd_data;
    exp_rd = mRead(rd_addr);
    checkOutput("status_out", status_out, m_status);
    checkOutput("epc_out", epc_out, m_epc);
    checkOutput("int_pending", {31'b0, int_pending}, {31'b0, mIntPending()});
    checkOutput("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_rv});
    if (m_rv) checkOutput("redirect_pc", redirect_pc, m_rpc);
    modelStep();
`ifdef CP0_MFC0_BYPASS_EN
    if (c_valid && c_mtc0 && c_cp0_addr == rd_addr) exp_rd = mRead(rd_addr);
`endif
    checkOutput("rd_data", got_rd, exp_rd);
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] addrs [7];
    logic [4:0] a;
    logic       found;
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd30};
    total = 0;
    bad = 0;
    reset = 1'b1;
    ext_int = '0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    repeat (2) @(negedge clk);

    checkOutput("rst_status", status_out, 32'h0040_0000);
    checkOutput("rst_epc", epc_out, 32'h0);
    checkOutput("rst_redirect", {31'b0, redirect_valid}, 32'h0);
    reset = 1'b0;

    // Free-running Count
    for (int i = 0; i < 10; i++) begin
      idle(5'd9);
      runCycle();
    end
    idle(5'd9);
    checkOutput("count_after_10", rd_data, 32'd5);

    // Timer match
    applyStimulus(1, 0, 0, 1, 0, 5'd9, 0, 0, 32'h0, 0, 0);          runCycle();
    applyStimulus(1, 0, 0, 1, 0, 5'd11, 0, 0, 32'd3, 0, 0);         runCycle();
    applyStimulus(1, 0, 0, 1, 0, 5'd12, 0, 0, 32'h0040_8001, 0, 0); runCycle();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      idle(5'd13);
      if (rd_data[30]) found = 1'b1;
      else runCycle();
    end
    checkOutput("ti_seen", {31'b0, found}, 32'h1);
    checkOutput("ti_cause", rd_data, 32'h4000_8000);
    checkOutput("ti_int_pending", {31'b0, int_pending}, 32'h1);
    idle(5'd9);
    checkOutput("ti_count", rd_data, 32'd3);
    applyStimulus(1, 0, 0, 1, 0, 5'd11, 0, 0, 32'd100, 0, 0);       runCycle();
    idle(5'd13);
    checkOutput("ti_cleared", rd_data, 32'h0);
    checkOutput("int_cleared", {31'b0, int_pending}, 32'h0);

    // AdEL in a delay slot with BEV=1
    applyStimulus(1, 1, 0, 0, 5'd4, 0, 0, 32'h8000_1004, 0, 32'hdeadbee0, 1); runCycle();
    idle(5'd8);
    checkOutput("exc_rv", {31'b0, redirect_valid}, 32'h1);
    checkOutput("exc_rpc", redirect_pc, 32'hbfc0_0380);
    checkOutput("exc_epc", epc_out, 32'h8000_1000);
    checkOutput("exc_status", status_out, 32'h0040_8003);
    checkOutput("exc_badv", rd_data, 32'hdeadbee0);
    runCycle();
    idle(5'd13);
    checkOutput("exc_cause", rd_data, 32'h8000_0010);
    checkOutput("exc_pulse", {31'b0, redirect_valid}, 32'h0);

    // Nested exception while EXL=1
    applyStimulus(1, 1, 0, 0, 5'd8, 0, 0, 32'h8000_3000, 0, 32'h1111_1111, 0); runCycle();
    idle(5'd8);
    checkOutput("nest_rpc", redirect_pc, 32'hbfc0_0380);
    checkOutput("nest_epc", epc_out, 32'h8000_1000);
    checkOutput("nest_badv", rd_data, 32'hdeadbee0);
    runCycle();
    idle(5'd13);
    checkOutput("nest_cause", rd_data, 32'h8000_0020);

    // ERET back to EPC
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); runCycle();
    idle(5'd0);
    checkOutput("eret_rpc", redirect_pc, 32'h8000_1000);
    checkOutput("eret_status", status_out, 32'h0040_8001);

    // Vectored interrupt with BEV=0, IV=1
    applyStimulus(1, 0, 0, 1, 0, 5'd12, 0, 0, 32'h0000_0001, 0, 0); runCycle();
    applyStimulus(1, 0, 0, 1, 0, 5'd13, 0, 0, 32'h0080_0000, 0, 0); runCycle();
    idle(5'd13);
    checkOutput("iv_cause", rd_data, 32'h8080_0020);
    applyStimulus(1, 1, 0, 0, 5'd0, 0, 0, 32'h8000_2000, 0, 0, 0); runCycle();
    idle(5'd13);
    checkOutput("int_rpc", redirect_pc, 32'h8000_0200);
    checkOutput("int_epc", epc_out, 32'h8000_2000);
    checkOutput("int_cause", rd_data, 32'h0080_0000);
    runCycle();
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); runCycle();
    idle(5'd0);
    checkOutput("eret2_rpc", redirect_pc, 32'h8000_2000);
    checkOutput("eret2_status", status_out, 32'h0000_0001);

    // Same-cycle MTC0/MFC0 of Status
    applyStimulus(1, 0, 0, 1, 0, 5'd12, 5'd12, 0, 32'h0000_ff01, 0, 0);
    #1;
`ifdef CP0_MFC0_BYPASS_EN
    checkOutput("mfc0_same_cycle", rd_data, 32'h0000_ff01);
`else
    checkOutput("mfc0_same_cycle", rd_data, 32'h0000_0001);
`endif
    runCycle();
    idle(5'd12);
    checkOutput("mfc0_after", rd_data, 32'h0000_ff01);

    // Count wrap
    applyStimulus(1, 0, 0, 1, 0, 5'd9, 0, 0, 32'hffff_ffff, 0, 0); runCycle();
    idle(5'd9); runCycle();
    idle(5'd9); runCycle();
    idle(5'd9);
    checkOutput("count_wrap", rd_data, 32'h0);

    // Randomized commits against the model
    for (int i = 0; i < 2000; i++) begin
      logic v, e, r, m, dly;
      logic [4:0] code, wa, ra;
      logic [31:0] wd;
      if ($urandom_range(0, 7) == 0) ext_int = N'($urandom);
      v   = ($urandom_range(0, 9) < 6);
      e   = ($urandom_range(0, 4) == 0);
      r   = ($urandom_range(0, 4) == 0);
      m   = $urandom_range(0, 1) == 1;
      dly = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       code = 5'd0;
        1:       code = 5'd4;
        2:       code = 5'd5;
        default: code = 5'($urandom);
      endcase
      wa = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 6)];
      ra = ($urandom_range(0, 7) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 6)];
      if (m && $urandom_range(0, 2) == 0) ra = wa;
      wd = $urandom;
      if (wa == 5'd11 && $urandom_range(0, 1) == 1) wd = mCount() + 32'($urandom_range(0, 3));
      if (wa == 5'd9 && $urandom_range(0, 1) == 1) wd = m_compare - 32'($urandom_range(0, 2));
      reset = ($urandom_range(0, 199) == 0);
      if (reset) v = 1'b0;
      applyStimulus(v, e, r, m, code, wa, ra, {$urandom} & 32'hffff_fffc, wd, $urandom, dly);
      runCycle();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_commit_unit.md
Name: cp0_commit_unit

Overview:
- Registered CP0 state and commit-side control for the mycpu pipeline.
- Successor to the combinational write-back CP0 update:
  - CP0 state lives in flops inside this block, not in a context struct passed through.
  - Count prescaler, interrupt line count and exception vectors are parametrised.
  - Adds interrupt-pending detection, interrupt vectoring (BEV/IV) and a registered redirect.
- Sits after the memory stage and beside the GPR write port; it consumes one committing instruction per cycle.

Parameters:
- N_EXT_INT, 6, number of external interrupt lines; legal range 1..6; line i maps to Cause.IP[2+i].
- COUNT_DIV, 2, cycles per Count increment; legal range ≥1.
- VEC_BEV_BASE, 32'hbfc00200, exception base when Status.BEV=1.
- VEC_NORM_BASE, 32'h80000000, exception base when Status.BEV=0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ext_int  in  N_EXT_INT  external interrupt levels, sampled every cycle
- c_valid  in  1  instruction commits this cycle
- c_pc  in  32  PC of committing instruction
- c_exc  in  1  committing instruction carries an exception
- c_code  in  5  ExcCode
- c_delayed  in  1  instruction sits in a branch delay slot
- c_badvaddr  in  32  faulting address
- c_eret  in  1  ERET commits
- c_mtc0  in  1  MTC0 commits
- c_cp0_addr  in  5  MTC0 destination
- c_wdata  in  32  MTC0 data
- rd_addr  in  5  MFC0 read address
- rd_data  out  32  MFC0 read data (combinational)
- int_pending  out  1  an enabled interrupt is pending
- redirect_valid  out  1  fetch redirect pulse
- redirect_pc  out  32  redirect target
- status_out  out  32  current Status register
- epc_out  out  32  current EPC register

Behaviour:
- Reset values:
  - Status=32'h0040_0000 (BEV=1); Cause, EPC, ErrorEPC, BadVAddr, Count, Compare = 0.
  - Prescaler=0; redirect_valid=0; redirect_pc=0.
  - Reset mid-operation overrides every other input in that cycle.
- Commit inputs are ignored when c_valid=0.
- Per-commit priority: c_exc > c_eret > c_mtc0.
- Count:
  - The prescaler counts 0..COUNT_DIV-1.
  - Count increments by 1 in the cycle the prescaler wraps, modulo 2^32; 32'hffffffff wraps to 0.
  - An MTC0 to reg 9 loads Count and clears the prescaler.
- Timer:
  - TI is set on the increment that makes Count equal Compare.
  - An MTC0 to reg 11 loads Compare and clears TI; if both happen in the same cycle, the write wins.
- Cause.IP:
  - IP[2+i] takes the registered ext_int[i] every cycle.
  - IP[7] = ext_int[5] | TI when N_EXT_INT=6; otherwise IP[7] = TI.
  - IP[1:0] are software bits, writable via MTC0 to Cause. MTC0 to Cause writes only IP[1:0] and IV; all other Cause bits are read-only.
- int_pending = IE & ~EXL & ~ERL & |(IP & IM), computed from registered state. The upstream stage converts it into an Int exception (code 0).
- Exception commit:
  - If EXL=0: EPC = c_delayed ? c_pc-4 : c_pc, and BD = c_delayed.
  - If EXL=1: EPC and BD are unchanged.
  - Then EXL=1 and ExcCode=c_code.
  - BadVAddr is written only for code 4 (AdEL) or 5 (AdES).
  - Next cycle: redirect_valid=1 with redirect_pc = base + off, where base follows BEV and off = (code==0 && IV) ? 32'h200 : 32'h180.
- ERET commit:
  - If ERL=1: ERL cleared, redirect_pc = ErrorEPC.
  - Otherwise: EXL cleared, redirect_pc = EPC.
  - Redirect uses pre-update values and is asserted the next cycle.
- MTC0 writable registers: 8, 9, 11, 12, 13, 14, 30. Other addresses are a no-op.
- redirect_valid is a one-cycle pulse. Back-to-back commits produce back-to-back pulses.
- rd_data returns the register selected by rd_addr. Unmapped addresses read 0.

Optional Feature:
- Macro CP0_MFC0_BYPASS_EN.
- Defined: when c_valid & c_mtc0 and c_cp0_addr == rd_addr in the same cycle, rd_data returns the value the register will hold after this cycle's write (masked per write rules).
- Undefined: rd_data always returns the current registered value; the pipeline must stall the MFC0 for one cycle.

Test Plan:
- Reset, COUNT_DIV=2, hold 10 cycles -> Count=5, Status=32'h00400000, redirect_valid never asserted.
- MTC0 Compare=3, Status IE=1 IM7=1 EXL=0 -> TI and IP[7] set when Count reaches 3; int_pending=1 the following cycle; MTC0 Compare=100 -> TI=0, int_pending=0.
- Exception code 4, c_pc=32'h80001004, c_delayed=1, BEV=1 -> next cycle redirect_valid=1, redirect_pc=32'hbfc00380; EPC=32'h80001000, BD=1, BadVAddr=c_badvaddr, EXL=1.
- Second exception code 8 while EXL=1 -> EPC unchanged, BadVAddr unchanged, ExcCode=8.
- BEV=0, IV=1, Int exception (code 0) -> redirect_pc=32'h80000200. ERET -> redirect_pc=EPC, EXL=0.
- MTC0 reg 12 plus MFC0 reg 12 in the same cycle -> with CP0_MFC0_BYPASS_EN: rd_data = new value; without: rd_data = old value.
